// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
//   Owns the fetch PC and issues single outstanding word reads to
//   instruction memory (req/gnt handshake, later rvalid). Returned words,
//   each tagged with the PC it was fetched from, go into a small FIFO that
//   decode drains with inst_valid/inst_ready. A redirect reloads the PC,
//   flushes the FIFO and squashes any fetch still in flight.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_req/imem_addr/imem_gnt request side of the memory handshake
//   imem_rvalid/imem_rdata      response side of the memory handshake
//   redirect/redirect_pc        PC reload pulse from downstream
//   inst/inst_pc/inst_valid     FIFO head towards decode (zero when empty)
//   inst_ready                  decode accepts the head
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    // REQ: may issue; WAIT: response owed and wanted; DROP: response owed
    // but squashed by a redirect, so it is swallowed on arrival.
    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    entry_t        fifo [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          handshake, push, pop;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        unique case (state)
            REQ: begin
                // Only request when the reply is guaranteed a FIFO slot.
                imem_req = rst_n & (count < DEPTH_C) & ~redirect;
                if (imem_req & imem_gnt)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (redirect)
                    state_nxt = imem_rvalid ? REQ : DROP;
                else if (imem_rvalid)
                    state_nxt = REQ;
            end
            DROP: begin
                // Leaves as soon as the squashed response has arrived, even
                // if another redirect lands in the same cycle.
                if (imem_rvalid)
                    state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    assign handshake = imem_req & imem_gnt;
    assign push      = (state == WAIT) & imem_rvalid & ~redirect;
    assign pop       = inst_valid & inst_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;

            if (redirect)
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (handshake)
                fetch_pc <= fetch_pc + 32'd4;

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // fetch_pc has already advanced past the outstanding word, so its
    // address is fetch_pc - 4 while in WAIT.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{data: imem_rdata, pc: fetch_pc - 32'd4};
    end

    assign head       = fifo[rd_ptr];
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head.data : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;
    assign imem_addr  = fetch_pc;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a transaction-level model (PC, outstanding/squashed
// flags, queue of {pc,data}) is checked against the DUT every cycle, and
// directed scenarios add literal expectations on the grant/delivery logs.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'h1357_9BDF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    // logs of what the DUT actually did
    logic [31:0] grants[$];
    int          gstamp[$];
    ent_t        pops[$];

    // memory responder state
    bit          hs_last  = 1'b0;
    bit          rst_last = 1'b1;
    logic [31:0] hs_addr  = '0;
    logic [31:0] raddr    = '0;
    int          left     = 0;

    // reference model
    logic [31:0] m_pc     = RESET_PC;
    logic [31:0] m_issued = '0;
    bit          m_out    = 1'b0;
    bit          m_sq     = 1'b0;
    ent_t        m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] gat(input int i);
        return (i < grants.size()) ? grants[i] : 'x;
    endfunction

    function automatic logic [31:0] pat(input int i);
        return (i < pops.size()) ? pops[i].pc : 'x;
    endfunction

    function automatic logic [31:0] dat(input int i);
        return (i < pops.size()) ? pops[i].data : 'x;
    endfunction

    // Compare, log, then advance the model with the inputs the next edge sees.
    always @(negedge clk) begin
        bit   e_req, e_val, hs, pp, do_push;
        ent_t e;
        e_req = rst_n && !m_out && (m_q.size() < DEPTH) && !redirect;
        e_val = m_q.size() > 0;
        chk("imem_req",   imem_req,   e_req);
        chk("imem_addr",  imem_addr,  m_pc);
        chk("inst_valid", inst_valid, e_val);
        chk("inst",       inst,       e_val ? m_q[0].data : 32'h0);
        chk("inst_pc",    inst_pc,    e_val ? m_q[0].pc   : 32'h0);

        hs_last  = rst_n && imem_req && imem_gnt;
        hs_addr  = imem_addr;
        rst_last = !rst_n;
        if (hs_last) begin
            grants.push_back(imem_addr);
            gstamp.push_back(cyc);
        end
        if (rst_n && inst_valid && inst_ready && !redirect) begin
            e.pc = inst_pc; e.data = inst;
            pops.push_back(e);
        end

        if (!rst_n) begin
            m_pc = RESET_PC; m_q.delete(); m_out = 0; m_sq = 0;
        end else if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (m_out) begin
                if (imem_rvalid) begin m_out = 0; m_sq = 0; end
                else m_sq = 1;
            end
        end else begin
            hs = e_req && imem_gnt;
            pp = e_val && inst_ready;
            do_push = 0;
            if (m_out && imem_rvalid) begin
                if (!m_sq) begin do_push = 1; e.pc = m_issued; e.data = imem_rdata; end
                m_out = 0; m_sq = 0;
            end
            if (pp) void'(m_q.pop_front());
            if (do_push) m_q.push_back(e);
            if (hs) begin m_issued = m_pc; m_pc = m_pc + 32'd4; m_out = 1; end
        end
        cyc++;
    end

    // Memory: answers each grant after 'lat' cycles with addr ^ KEY.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (rst_last) left = 0;
        else begin
            if (hs_last) begin raddr = hs_addr; left = lat; end
            if (left > 0) begin
                left--;
                if (left == 0) begin imem_rvalid = 1'b1; imem_rdata = raddr ^ KEY; end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        grants.delete(); gstamp.delete(); pops.delete();
    endtask

    initial begin
        rst_n = 0; redirect = 0; redirect_pc = '0; imem_gnt = 0; inst_ready = 0;

        // 1: streaming, 1-cycle memory, decode always ready
        imem_gnt = 1; lat = 1; inst_ready = 1;
        do_reset();
        tick(6);
        imem_gnt = 0;
        tick(4);
        chk("s1_ngrants", grants.size(), 3);
        chk("s1_g0", gat(0), 32'h0);
        chk("s1_g1", gat(1), 32'h4);
        chk("s1_g2", gat(2), 32'h8);
        if (gstamp.size() >= 3) begin
            chk("s1_gap01", gstamp[1] - gstamp[0], 2);
            chk("s1_gap12", gstamp[2] - gstamp[1], 2);
        end else chk("s1_stamps", gstamp.size(), 3);
        chk("s1_p0", pat(0), 32'h0);
        chk("s1_p1", pat(1), 32'h4);
        chk("s1_p2", pat(2), 32'h8);
        chk("s1_d1", dat(1), 32'h4 ^ KEY);

        // 2: decode stalled, FIFO fills at two entries
        imem_gnt = 1; lat = 1; inst_ready = 0;
        do_reset();
        tick(10);
        @(negedge clk);
        chk("s2_ngrants", grants.size(), 2);
        chk("s2_req_full", imem_req, 1'b0);
        chk("s2_valid", inst_valid, 1'b1);
        chk("s2_head_pc", inst_pc, 32'h0);
        tick(1);
        inst_ready = 1;
        tick(4);
        chk("s2_g2", gat(2), 32'h8);
        chk("s2_p0", pat(0), 32'h0);
        chk("s2_p1", pat(1), 32'h4);
        imem_gnt = 0;

        // 3: grant withheld for five cycles
        lat = 1; inst_ready = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_hold_req", imem_req, 1'b1);
            chk("s3_hold_addr", imem_addr, 32'h0);
        end
        tick(1);
        imem_gnt = 1;
        @(negedge clk);
        chk("s3_g_addr", imem_addr, 32'h0);
        tick(1);
        imem_gnt = 0;
        @(negedge clk);
        chk("s3_next_addr", imem_addr, 32'h4);
        tick(3);
        chk("s3_ngrants", grants.size(), 1);

        // 4: redirect while waiting, response arrives two cycles later
        imem_gnt = 1; lat = 3; inst_ready = 1;
        do_reset();
        tick(1);
        redirect = 1; redirect_pc = 32'h0000_0103; lat = 1;
        tick(1);
        redirect = 0;
        @(negedge clk);
        chk("s4_empty", inst_valid, 1'b0);
        chk("s4_noreq", imem_req, 1'b0);
        tick(6);
        chk("s4_g0", gat(0), 32'h0);
        chk("s4_g1", gat(1), 32'h100);
        chk("s4_p0", pat(0), 32'h100);
        chk("s4_d0", dat(0), 32'h100 ^ KEY);
        imem_gnt = 0;

        // 5: redirect coinciding with rvalid and a pop
        imem_gnt = 1; lat = 1; inst_ready = 0;
        do_reset();
        tick(3);
        inst_ready = 1; redirect = 1; redirect_pc = 32'h0000_0200;
        tick(1);
        redirect = 0;
        @(negedge clk);
        chk("s5_empty", inst_valid, 1'b0);
        chk("s5_req", imem_req, 1'b1);
        chk("s5_addr", imem_addr, 32'h200);
        tick(4);
        chk("s5_p0", pat(0), 32'h200);
        chk("s5_g2", gat(2), 32'h200);
        imem_gnt = 0;

        // 6: wrap at top of address space, then reset mid-WAIT
        imem_gnt = 1; lat = 2; inst_ready = 1;
        do_reset();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 0;
        tick(4);
        chk("s6_g0", gat(0), 32'hFFFF_FFFC);
        chk("s6_g1", gat(1), 32'h0);
        chk("s6_p0", pat(0), 32'hFFFF_FFFC);
        rst_n = 0;
        tick(1);
        @(negedge clk);
        chk("s6_rst_valid", inst_valid, 1'b0);
        chk("s6_rst_req", imem_req, 1'b0);
        chk("s6_rst_addr", imem_addr, RESET_PC);
        tick(1);
        rst_n = 1;
        grants.delete(); pops.delete(); gstamp.delete();
        tick(3);
        chk("s6_after_rst", gat(0), RESET_PC);
        imem_gnt = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
